// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin write arbiter for a shared register with q/qb outputs (lock mode: DFF_BANK_ARBITER_LOCK_EN)
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qb,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    win;
    logic             found;
    logic [IW-1:0]    sel;
    logic [WIDTH-1:0] wsel;

`ifdef DFF_BANK_ARBITER_LOCK_EN
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Find the first requester after the last winner, wrapping NREQ-1 -> 0
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    // Data source: the locked owner while holding, otherwise this cycle's winner
    always_comb begin
`ifdef DFF_BANK_ARBITER_LOCK_EN
        sel = (state == LOCKED) ? owner : win;
`else
        sel = win;
`endif
    end

    // Slice out only the selected requester's data so other lanes never reach q
    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == sel) begin
                wsel = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign qb = ~q;

`ifdef DFF_BANK_ARBITER_LOCK_EN
    // Arbitration / lock FSM with registered grant, owner, data and busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB;
            gnt   <= '0;
            owner <= IW'(NREQ-1);
            ptr   <= IW'(NREQ-1);
            q     <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << win;
                        q     <= wsel;
                        owner <= win;
                        ptr   <= win;
                        if (lock[win]) begin
                            state <= LOCKED;
                            busy  <= 1'b1;
                        end
                    end else begin
                        gnt <= '0;
                    end
                end
                LOCKED: begin
                    if (req[owner] && lock[owner]) begin
                        gnt <= NREQ'(1) << owner;
                        q   <= wsel;
                    end else begin
                        // Release costs one dead cycle before arbitration resumes
                        gnt   <= '0;
                        state <= ARB;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    // One-cycle round-robin grants with registered grant, owner and data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt   <= '0;
            owner <= IW'(NREQ-1);
            ptr   <= IW'(NREQ-1);
            q     <= '0;
        end else if (found) begin
            gnt   <= NREQ'(1) << win;
            q     <= wsel;
            owner <= win;
            ptr   <= win;
        end else begin
            gnt <= '0;
        end
    end

    assign busy = 1'b0;
`endif

endmodule
